slice_adder_seq: RTL and testbench



---
 rtl/slice_adder_seq.sv | 126 ++++++++++++
 tb/tb_slice_adder_seq.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/slice_adder_seq.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared SLICE-bit ripple stage.
// Processes slices LSB first with a registered carry, behind valid/ready handshakes.
module slice_adder_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             busy
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int unsigned SW     = SLICE + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_r, a_nxt;
    logic [WIDTH-1:0] b_r, b_nxt;
    logic             sub_r, sub_nxt;
    logic             carry, carry_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_nxt, ovf_nxt;
    logic             in_ready_nxt, out_valid_nxt, busy_nxt;

    int unsigned      off;
    logic [SLICE-1:0] a_s, b_s;
    logic [SW-1:0]    stage;
    logic             msb_cin;

    // Shared slice adder; B is inverted for subtract, carry register supplies the +1.
    always_comb begin
        off     = 32'(idx) * SLICE;
        a_s     = SLICE'(a_r >> off);
        b_s     = SLICE'(b_r >> off) ^ {SLICE{sub_r}};
        stage   = {1'b0, a_s} + {1'b0, b_s} + SW'(carry);
        msb_cin = a_s[SLICE-1] ^ b_s[SLICE-1] ^ stage[SLICE-1];
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_r;
        b_nxt     = b_r;
        sub_nxt   = sub_r;
        carry_nxt = carry;
        idx_nxt   = idx;
        sum_nxt   = Sum;
        cout_nxt  = Cout;
        ovf_nxt   = Ovf;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_nxt     = A;
                    b_nxt     = B;
                    sub_nxt   = sub;
                    carry_nxt = sub ? 1'b1 : Cin;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                sum_nxt[off +: SLICE] = stage[SLICE-1:0];
                carry_nxt             = stage[SLICE];
                if (idx == IW'(NSLICE - 1)) begin
                    cout_nxt  = stage[SLICE];
                    ovf_nxt   = msb_cin ^ stage[SLICE];
                    idx_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        in_ready_nxt  = (state_nxt == IDLE);
        out_valid_nxt = (state_nxt == DONE);
        busy_nxt      = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            sub_r     <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            a_r       <= a_nxt;
            b_r       <= b_nxt;
            sub_r     <= sub_nxt;
            carry     <= carry_nxt;
            idx       <= idx_nxt;
            Sum       <= sum_nxt;
            Cout      <= cout_nxt;
            Ovf       <= ovf_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_slice_adder_seq.sv
// Scoreboard bench for slice_adder_seq: driver queues expected results,
// monitor checks them on each output handshake.
module tb_slice_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic        Cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Sum;
    logic        Cout, Ovf, busy;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    slice_adder_seq #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("stray_result", 32'(Sum), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum",  32'(Sum),  32'(e.sum));
                chk("cout", 32'(Cout), 32'(e.cout));
                chk("ovf",  32'(Ovf),  32'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Issue one operation, check busy/in_ready during RUN and the 4-cycle latency.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
        int lat = 0;
        wait_ready();
        A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a; B = ~b; Cin = ~c;
        q.push_back('{sum: es, cout: ec, ovf: eo});
        chk("busy_after_accept", {30'd0, in_ready, busy}, 32'd1);
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
            if (in_ready) chk("in_ready_in_run", 32'(in_ready), 32'd0);
        end
        chk("latency", 32'(lat), 32'd4);
    endtask

    task automatic finish_handshake();
        @(posedge clk); #1;
        chk("idle_after_hs", {29'd0, in_ready, out_valid, busy}, 32'b100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_ctrl", {27'd0, in_ready, out_valid, busy, Cout, Ovf}, 32'b10000);
        chk("reset_sum", 32'(Sum), 32'd0);

        send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); finish_handshake();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); finish_handshake();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0); finish_handshake();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); finish_handshake();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); finish_handshake();
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0); finish_handshake();
        send(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0); finish_handshake();

        // Backpressure: result must hold while input side is ignored.
        out_ready = 1'b0;
        send(16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~i[0];
            A = 16'($urandom); B = 16'($urandom); sub = i[1];
            @(negedge clk);
            chk("bp_ctrl", {29'd0, out_valid, in_ready, busy}, 32'b101);
            chk("bp_sum", {15'd0, Sum, Cout}, {15'd0, 16'h0FFF, 1'b0});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready", 32'(in_ready), 32'd1);

        // Reset during RUN at slice 2: the operation must vanish.
        wait_ready();
        A = 16'hAAAA; B = 16'h5555; Cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ctrl", {27'd0, in_ready, out_valid, busy, Cout, Ovf}, 32'b10000);
        chk("midrst_sum", 32'(Sum), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_valid), 32'd0);

        send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0); finish_handshake();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
